uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the shared UART transmit arbiter.
// master = requesters plus uart_tx (environment), slave = the arbiter.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic               tx_busy;
   logic               arb_busy;
   logic               wdog_abort;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, grant, tx_start, tx_data,
      input  arb_busy, wdog_abort
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, grant, tx_start, tx_data,
      output arb_busy, wdog_abort
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one uart_tx from N_REQ streams.
// Define UART_TX_ARB_WDOG_EN to build in the stalled-owner watchdog.
module uart_tx_arbiter #(
   parameter int N_REQ       = 3,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 1 || N_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: illegal parameters");
   end

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      WAIT_ACK,
      WAIT_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ready_q, ready_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    last_q, last_d;
   logic [7:0]       data_q, data_d;
   logic             flag_q, flag_d;
   logic             start_q, start_d;
   logic             abort_q, abort_d;

   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic             own_vld;
   logic             own_last;
   logic [7:0]       own_byte;
   int               idx;

`ifdef UART_TX_ARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   assign own_vld  = bus.req_valid[owner_q];
   assign own_last = bus.req_last[owner_q];
   assign own_byte = bus.req_data[{owner_q, 3'b000} +: 8];

   // Descending scan so the nearest requester after last_q wins.
   always_comb begin
      pick     = last_q;
      pick_vld = 1'b0;
      idx      = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = int'(last_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (bus.req_valid[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      data_d  = data_q;
      flag_d  = flag_q;
      start_d = 1'b0;
      ready_d = '0;
      abort_d = 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
      cnt_d   = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = N_REQ'(1) << pick;
               owner_d = pick;
               state_d = GRANTED;
            end
         end
         GRANTED: begin
            if (own_vld && !bus.tx_busy) begin
               start_d = 1'b1;
               ready_d = grant_q;
               data_d  = own_byte;
               flag_d  = own_last;
               state_d = WAIT_ACK;
            end
`ifdef UART_TX_ARB_WDOG_EN
            else if (!own_vld) begin
               if (cnt_q == CW'(WDOG_CYCLES - 1)) begin
                  abort_d = 1'b1;
                  grant_d = '0;
                  last_d  = owner_q;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
`endif
         end
         WAIT_ACK: begin
            if (bus.tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               if (flag_q) begin
                  grant_d = '0;
                  last_d  = owner_q;
                  state_d = IDLE;
               end else begin
                  state_d = GRANTED;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ready_q <= '0;
         owner_q <= '0;
         last_q  <= IW'(N_REQ - 1);
         data_q  <= '0;
         flag_q  <= 1'b0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         data_q  <= data_d;
         flag_q  <= flag_d;
         start_q <= start_d;
         abort_q <= abort_d;
      end
   end

`ifdef UART_TX_ARB_WDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   assign bus.grant      = grant_q;
   assign bus.req_ready  = ready_q;
   assign bus.tx_start   = start_q;
   assign bus.tx_data    = data_q;
   assign bus.arb_busy   = (state_q != IDLE);
   assign bus.wdog_abort = abort_q;
endmodule
